// File: rtl/dataflow_stream_pkg.sv
// Shared dataflow FSM types: state encodings for the stream generator and the
// gate that consumes its idx/cont pair downstream.
package dataflow_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_EMIT  = 2'b01,
    S_FINAL = 2'b10
  } stream_state_e;

  // Gate FSM: drops the head cont token, then pairs cont with value tokens.
  typedef enum logic [1:0] {
    G_DROP_HEAD = 2'b00,
    G_PASS      = 2'b01,
    G_DONE      = 2'b10
  } gate_state_e;

  localparam logic [1:0] STATE_BITS = 2'd2;

endpackage

// File: rtl/dataflow_stream.sv
// Loop index generator: joins start/step/bound, emits N indices on idx and
// N ones followed by a single zero on cont, through a two-way fork.
module dataflow_stream
  import dataflow_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] start_data,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [WIDTH-1:0] step_data,
  input  logic             bound_valid,
  output logic             bound_ready,
  input  logic [WIDTH-1:0] bound_data,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [WIDTH-1:0] idx_data,
  output logic             cont_valid,
  input  logic             cont_ready,
  output logic             cont_data
);

  stream_state_e    state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] bound_q, bound_d;
  logic             idx_sent_q, idx_sent_d;
  logic             cont_sent_q, cont_sent_d;

  logic             cfg_join;
  logic             cfg_ready;
  logic             idx_done;
  logic             cont_done;
  logic [WIDTH:0]   nxt;

  assign cfg_join = start_valid & step_valid & bound_valid;
  assign nxt      = {1'b0, cur_q} + {1'b0, step_q};

  // Readies are forced low while reset is held, even though the FSM sits in IDLE.
  assign start_ready = cfg_ready & rst_n;
  assign step_ready  = cfg_ready & rst_n;
  assign bound_ready = cfg_ready & rst_n;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    step_d      = step_q;
    bound_d     = bound_q;
    idx_sent_d  = idx_sent_q;
    cont_sent_d = cont_sent_q;
    cfg_ready   = 1'b0;
    idx_valid   = 1'b0;
    idx_data    = '0;
    cont_valid  = 1'b0;
    cont_data   = 1'b0;
    idx_done    = 1'b0;
    cont_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cfg_ready = cfg_join;
        if (cfg_join) begin
          cur_d       = start_data;
          step_d      = step_data;
          bound_d     = bound_data;
          idx_sent_d  = 1'b0;
          cont_sent_d = 1'b0;
          if ((step_data != '0) && (start_data < bound_data)) begin
            state_d = S_EMIT;
          end else begin
            state_d = S_FINAL;
          end
        end
      end

      S_EMIT: begin
        idx_valid  = ~idx_sent_q;
        idx_data   = cur_q;
        cont_valid = ~cont_sent_q;
        cont_data  = 1'b1;
        idx_done   = idx_sent_q | idx_ready;
        cont_done  = cont_sent_q | cont_ready;
        if (idx_done && cont_done) begin
          idx_sent_d  = 1'b0;
          cont_sent_d = 1'b0;
          if (nxt[WIDTH] || (nxt[WIDTH-1:0] >= bound_q)) begin
            state_d = S_FINAL;
          end else begin
            cur_d = nxt[WIDTH-1:0];
          end
        end else begin
          // Remember which half of the pair already left so it is not resent.
          idx_sent_d  = idx_done;
          cont_sent_d = cont_done;
        end
      end

      S_FINAL: begin
        cont_valid = 1'b1;
        cont_data  = 1'b0;
        if (cont_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      step_q      <= '0;
      bound_q     <= '0;
      idx_sent_q  <= 1'b0;
      cont_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      step_q      <= step_d;
      bound_q     <= bound_d;
      idx_sent_q  <= idx_sent_d;
      cont_sent_q <= cont_sent_d;
    end
  end

endmodule

// File: tb/tb_dataflow_stream.sv
// Table-driven bench with a token scoreboard for dataflow_stream (WIDTH=8).
module tb_dataflow_stream;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start_valid, start_ready;
  logic [W-1:0] start_data;
  logic         step_valid, step_ready;
  logic [W-1:0] step_data;
  logic         bound_valid, bound_ready;
  logic [W-1:0] bound_data;
  logic         idx_valid, idx_ready;
  logic [W-1:0] idx_data;
  logic         cont_valid, cont_ready;
  logic         cont_data;

  dataflow_stream #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_data  (start_data),
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .step_data   (step_data),
    .bound_valid (bound_valid),
    .bound_ready (bound_ready),
    .bound_data  (bound_data),
    .idx_valid   (idx_valid),
    .idx_ready   (idx_ready),
    .idx_data    (idx_data),
    .cont_valid  (cont_valid),
    .cont_ready  (cont_ready),
    .cont_data   (cont_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]      start;
    logic [W-1:0]      step;
    logic [W-1:0]      bound;
    int                n;
    logic [3:0][W-1:0] idx;
    int                mode;   // 0: readies high, 1: uneven readies
  } vec_t;

  vec_t         vecs [10];
  logic [W-1:0] q_idx [$];
  logic         q_cont [$];

  int           checks;
  int           errors;
  int           mode;
  int           k;
  logic         cfg_drop;
  logic         hold_i, hold_c;
  logic [W-1:0] hold_i_data;
  logic         hold_c_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [W-1:0] e_i;
    logic         e_c;
    if (!rst_n) begin
      hold_i = 1'b0;
      hold_c = 1'b0;
      return;
    end
    if (q_cont.size() == 0) begin
      check("no_stray_valid", {30'd0, idx_valid, cont_valid}, 0);
    end
    if (hold_i) begin
      check("idx_stall_valid", {31'd0, idx_valid}, 1);
      check("idx_stall_data", {24'd0, idx_data}, {24'd0, hold_i_data});
    end
    if (hold_c) begin
      check("cont_stall_valid", {31'd0, cont_valid}, 1);
      check("cont_stall_data", {31'd0, cont_data}, {31'd0, hold_c_data});
    end
    if (idx_valid && idx_ready) begin
      check("idx_expected", {31'd0, q_idx.size() > 0}, 1);
      if (q_idx.size() > 0) begin
        e_i = q_idx.pop_front();
        check("idx_data", {24'd0, idx_data}, {24'd0, e_i});
        $display("idx token %0d (expected %0d)", idx_data, e_i);
      end
    end
    if (cont_valid && cont_ready) begin
      check("cont_expected", {31'd0, q_cont.size() > 0}, 1);
      if (q_cont.size() > 0) begin
        e_c = q_cont.pop_front();
        check("cont_data", {31'd0, cont_data}, {31'd0, e_c});
        $display("cont token %0d (expected %0d)", cont_data, e_c);
      end
    end
    hold_i      = idx_valid & ~idx_ready;
    hold_i_data = idx_data;
    hold_c      = cont_valid & ~cont_ready;
    hold_c_data = cont_data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cfg_drop) begin
      start_valid = 1'b0;
      step_valid  = 1'b0;
      bound_valid = 1'b0;
      cfg_drop    = 1'b0;
    end
    k++;
    if (mode == 1) begin
      idx_ready  = k[0];
      cont_ready = ((k % 4) == 3);
    end else begin
      idx_ready  = 1'b1;
      cont_ready = 1'b1;
    end
    @(negedge clk);
    monitor();
  endtask

  // Offer a config (checking the join), push its expected tokens, fire it.
  task automatic fire_cfg(input vec_t v);
    mode        = v.mode;
    start_data  = v.start;
    step_data   = v.step;
    bound_data  = v.bound;
    start_valid = 1'b1;
    step_valid  = 1'b1;
    bound_valid = 1'b0;
    #1;
    check("cfg_partial", {29'd0, start_ready, step_ready, bound_ready}, 0);
    bound_valid = 1'b1;
    #1;
    check("cfg_join", {29'd0, start_ready, step_ready, bound_ready}, 7);
    for (int i = 0; i < v.n; i++) begin
      q_idx.push_back(v.idx[i]);
      q_cont.push_back(1'b1);
    end
    q_cont.push_back(1'b0);
    $display("config start=%0d step=%0d bound=%0d mode=%0d expect %0d idx", v.start, v.step, v.bound, v.mode, v.n);
    cfg_drop = 1'b1;
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    fire_cfg(v);
    cyc = 1;
    while (q_cont.size() != 0 && cyc < 300) begin
      tick();
      cyc++;
    end
    check("drain", q_cont.size() + q_idx.size(), 0);
    q_idx.delete();
    q_cont.delete();
    if (v.mode == 0) begin
      check("cycles_to_final", cyc, v.n + 1);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; mode = 0; k = 0; cfg_drop = 1'b0;
    hold_i = 1'b0; hold_c = 1'b0; hold_i_data = '0; hold_c_data = 1'b0;

    vecs[0] = '{8'd0,   8'd1,   8'd4,   4, {8'd3, 8'd2, 8'd1, 8'd0},     0};
    vecs[1] = '{8'd5,   8'd2,   8'd5,   0, {8'd0, 8'd0, 8'd0, 8'd0},     0};
    vecs[2] = '{8'd0,   8'd0,   8'd10,  0, {8'd0, 8'd0, 8'd0, 8'd0},     0};
    vecs[3] = '{8'd250, 8'd4,   8'd255, 2, {8'd0, 8'd0, 8'd254, 8'd250}, 0};
    vecs[4] = '{8'd0,   8'd3,   8'd9,   3, {8'd0, 8'd6, 8'd3, 8'd0},     1};
    vecs[5] = '{8'd7,   8'd1,   8'd8,   1, {8'd0, 8'd0, 8'd0, 8'd7},     0};
    vecs[6] = '{8'd1,   8'd100, 8'd255, 3, {8'd0, 8'd201, 8'd101, 8'd1}, 1};
    vecs[7] = '{8'd0,   8'd1,   8'd4,   4, {8'd3, 8'd2, 8'd1, 8'd0},     1};
    vecs[8] = '{8'd10,  8'd5,   8'd3,   0, {8'd0, 8'd0, 8'd0, 8'd0},     1};
    vecs[9] = '{8'd254, 8'd1,   8'd255, 1, {8'd0, 8'd0, 8'd0, 8'd254},   0};

    // Reset with everything asserted: outputs must all be quiet.
    rst_n = 1'b0;
    start_valid = 1'b1; step_valid = 1'b1; bound_valid = 1'b1;
    start_data = 8'd1; step_data = 8'd1; bound_data = 8'd3;
    idx_ready = 1'b1; cont_ready = 1'b1;
    @(negedge clk);
    check("rst_readies", {29'd0, start_ready, step_ready, bound_ready}, 0);
    check("rst_valids", {30'd0, idx_valid, cont_valid}, 0);
    check("rst_data", {23'd0, idx_data, cont_data}, 0);
    start_valid = 1'b0; step_valid = 1'b0; bound_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end

    // Reset mid-loop after two of four indices have been taken.
    fire_cfg(vecs[0]);
    tick();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    start_valid = 1'b1; step_valid = 1'b1; bound_valid = 1'b1;
    q_idx.delete();
    q_cont.delete();
    @(negedge clk);
    check("midrst_valids", {30'd0, idx_valid, cont_valid}, 0);
    check("midrst_readies", {29'd0, start_ready, step_ready, bound_ready}, 0);
    check("midrst_data", {23'd0, idx_data, cont_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bound_valid = 1'b0;
    #1;
    check("post_rst_partial", {29'd0, start_ready, step_ready, bound_ready}, 0);
    start_valid = 1'b0; step_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    run_vec(vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
